// File: rtl/shake_squeeze_collector_pkg.sv
// Shared types and helpers for the SHAKE squeeze collector.
// Holds the FSM state encoding and the lane-index sizing used by the top and the packer.
package shake_squeeze_collector_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_FORCE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // A single-lane packer still needs a 1-bit index register.
   function automatic int idx_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   localparam int WOUT_DEF  = 32;
   localparam int W_BUS_DEF = 128;
   localparam int RATIO     = W_BUS_DEF / WOUT_DEF;
   localparam int IDX_W     = idx_width(RATIO);

endpackage

// File: rtl/shake_word_packer.sv
// Little-endian lane packer: squeeze words fill lanes from the LSB upward.
// Lanes are zeroed on clear, so a short final beat carries zeros in its unused lanes.
module shake_word_packer
   import shake_squeeze_collector_pkg::*;
#(
   parameter int WOUT  = 32,
   parameter int W_BUS = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr,
   input  logic             last,
   input  logic [WOUT-1:0]  data,
   output logic [W_BUS-1:0] lanes,
   output logic             full
);

   localparam int R  = W_BUS / WOUT;
   localparam int IW = idx_width(R);

   logic [R-1:0][WOUT-1:0] lane_q;
   logic [IW-1:0]          idx;
   logic                   at_end;

   assign at_end = (idx == IW'(R - 1)) || last;
   assign full   = wr && at_end;
   assign lanes  = lane_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q <= '0;
         idx    <= '0;
      end else if (clear) begin
         lane_q <= '0;
         idx    <= '0;
      end else if (wr) begin
         lane_q[idx] <= data;
         idx         <= at_end ? '0 : idx + IW'(1);
      end
   end

endmodule

// File: rtl/shake_squeeze_collector.sv
// Pulls a requested number of squeeze words from the Keccak core, emits packed beats,
// then stops the core through the force_done / force_done_ack handshake.
module shake_squeeze_collector
   import shake_squeeze_collector_pkg::*;
#(
   parameter int WOUT  = 32,
   parameter int W_BUS = 128,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] out_len,
   input  logic [WOUT-1:0]  s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [W_BUS-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             force_done,
   input  logic             force_done_ack,
   output logic             busy,
   output logic             done
);

   state_t           state, state_n;
   logic [LEN_W-1:0] remaining, remaining_n;
   logic             m_valid_n, m_last_n, force_done_n, done_n;
   logic             take, pk_clear, pk_full;

   // Backpressure: no new words while a beat is waiting, so lanes never overwrite.
   assign s_ready = (state == S_COLLECT) && !m_valid;
   assign take    = s_valid && s_ready;

   shake_word_packer #(.WOUT(WOUT), .W_BUS(W_BUS)) u_packer (
      .clk   (clk),
      .rst   (rst),
      .clear (pk_clear),
      .wr    (take),
      .last  (remaining == LEN_W'(1)),
      .data  (s_data),
      .lanes (m_data),
      .full  (pk_full)
   );

   always_comb begin
      state_n      = state;
      remaining_n  = remaining;
      m_valid_n    = m_valid;
      m_last_n     = m_last;
      force_done_n = force_done;
      done_n       = 1'b0;
      pk_clear     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               remaining_n = out_len;
               pk_clear    = 1'b1;
               if (out_len == '0) begin
                  state_n      = S_FORCE;
                  force_done_n = 1'b1;
               end else begin
                  state_n = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (take && remaining != '0)
               remaining_n = remaining - LEN_W'(1);
            if (pk_full) begin
               m_valid_n = 1'b1;
               m_last_n  = (remaining == LEN_W'(1));
            end
            if (m_valid && m_ready) begin
               m_valid_n = 1'b0;
               m_last_n  = 1'b0;
               pk_clear  = 1'b1;
               if (m_last) begin
                  state_n      = S_FORCE;
                  force_done_n = 1'b1;
               end
            end
         end
         S_FORCE: begin
            if (force_done_ack) begin
               force_done_n = 1'b0;
               state_n      = S_DONE;
               done_n       = 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         remaining  <= '0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         force_done <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         remaining  <= remaining_n;
         m_valid    <= m_valid_n;
         m_last     <= m_last_n;
         force_done <= force_done_n;
         done       <= done_n;
         busy       <= (state_n != S_IDLE);
      end
   end

endmodule
